// File: rtl/perf_counter_driver.sv
// perf_counter_driver: turns per-section go/stop/reset pulses and snapshot requests
// into Avalon-MM writes/reads on the performance counter control slave.
module perf_counter_driver #(
    parameter int NUM_SECTIONS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  sec_go,
    input  logic [7:0]  sec_stop,
    input  logic        global_reset_req,
    input  logic        snap_req,
    input  logic [2:0]  snap_sel,
    output logic [63:0] snap_time,
    output logic [31:0] snap_events,
    output logic        snap_valid,
    output logic [15:0] dropped_count,
    output logic        busy,
    output logic [4:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic        avm_begintransfer,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);
    localparam logic [7:0] SEC_MASK = 8'((9'd1 << NUM_SECTIONS) - 9'd1);
    localparam logic [1:0] K_RST = 2'd0, K_STOP = 2'd1, K_GO = 2'd2;
    typedef enum logic [2:0] {IDLE, WR, RD0, RD1, RD2, CAP} state_t;
    state_t      state;
    logic [1:0]  widx, wr_kind;
    logic [2:0]  wr_sec, snap_idx, stop_s, go_s;
    logic [7:0]  go_pend, stop_pend, go_req, stop_req, go_clr, stop_clr;
    logic        rst_pend, snap_pend, rst_clr, snap_clr, wr_acc, rd_active;
    logic        snap_set, snap_drop, stop_hit, go_hit;
    logic [31:0] lo_q, hi_q;
    logic [4:0]  drops;
    logic [16:0] drop_sum;

    assign go_req    = sec_go & SEC_MASK;
    assign stop_req  = sec_stop & SEC_MASK;
    assign wr_acc    = state == WR && !avm_waitrequest;
    assign go_clr    = wr_acc && wr_kind == K_GO ? 8'b1 << wr_sec : 8'b0;
    assign stop_clr  = wr_acc && wr_kind == K_STOP ? 8'b1 << wr_sec : 8'b0;
    assign rst_clr   = wr_acc && wr_kind == K_RST;
    assign snap_clr  = state == RD0 && !avm_waitrequest;
    assign rd_active = state inside {RD0, RD1, RD2, CAP};
    assign snap_drop = snap_req && (snap_pend || rd_active);
    assign snap_set  = snap_req && !snap_drop && {1'b0, snap_sel} < 4'(NUM_SECTIONS);
    assign drops     = 5'($countones(go_req & go_pend & ~go_clr))
                     + 5'($countones(stop_req & stop_pend & ~stop_clr))
                     + 5'(global_reset_req && rst_pend && !rst_clr) + 5'(snap_drop);
    assign drop_sum  = {1'b0, dropped_count} + 17'(drops);
    assign busy      = state != IDLE || |go_pend || |stop_pend || rst_pend || snap_pend;

    always_comb begin
        stop_hit = 1'b0;
        stop_s   = 3'd0;
        go_hit   = 1'b0;
        go_s     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (stop_pend[i]) begin
                stop_hit = 1'b1;
                stop_s   = 3'(i);
            end
            if (go_pend[i]) begin
                go_hit = 1'b1;
                go_s   = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            widx              <= 2'd0;
            wr_kind           <= K_RST;
            wr_sec            <= 3'd0;
            snap_idx          <= 3'd0;
            go_pend           <= 8'd0;
            stop_pend         <= 8'd0;
            rst_pend          <= 1'b0;
            snap_pend         <= 1'b0;
            lo_q              <= 32'd0;
            hi_q              <= 32'd0;
            snap_time         <= 64'd0;
            snap_events       <= 32'd0;
            snap_valid        <= 1'b0;
            dropped_count     <= 16'd0;
            avm_address       <= 5'd0;
            avm_write         <= 1'b0;
            avm_read          <= 1'b0;
            avm_begintransfer <= 1'b0;
            avm_writedata     <= 32'd0;
        end else begin
            go_pend           <= (go_pend & ~go_clr) | go_req;
            stop_pend         <= (stop_pend & ~stop_clr) | stop_req;
            rst_pend          <= (rst_pend && !rst_clr) || global_reset_req;
            dropped_count     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            avm_begintransfer <= 1'b0;
            snap_valid        <= 1'b0;
            if (snap_set) begin
                snap_pend <= 1'b1;
                snap_idx  <= snap_sel;
            end else if (snap_clr) begin
                snap_pend <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rst_pend) begin
                        state             <= WR;
                        avm_write         <= 1'b1;
                        avm_begintransfer <= 1'b1;
                        avm_address       <= 5'd0;
                        avm_writedata     <= 32'd1;
                        wr_kind           <= K_RST;
                    end else if (stop_hit) begin
                        state             <= WR;
                        avm_write         <= 1'b1;
                        avm_begintransfer <= 1'b1;
                        avm_address       <= {stop_s, 2'b00};
                        avm_writedata     <= 32'd0;
                        wr_kind           <= K_STOP;
                        wr_sec            <= stop_s;
                    end else if (go_hit) begin
                        state             <= WR;
                        avm_write         <= 1'b1;
                        avm_begintransfer <= 1'b1;
                        avm_address       <= {go_s, 2'b01};
                        avm_writedata     <= 32'd0;
                        wr_kind           <= K_GO;
                        wr_sec            <= go_s;
                    end else if (snap_pend) begin
                        state             <= RD0;
                        avm_read          <= 1'b1;
                        avm_begintransfer <= 1'b1;
                        avm_address       <= {snap_idx, 2'b00};
                        widx              <= 2'd0;
                    end
                end
                WR: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RD0, RD1, RD2: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= CAP;
                    end
                end
                CAP: begin
                    widx <= widx + 2'd1;
                    // all 96 bits publish together on the last word
                    if (widx == 2'd2) begin
                        snap_time   <= {hi_q, lo_q};
                        snap_events <= avm_readdata;
                        snap_valid  <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        if (widx == 2'd0) lo_q <= avm_readdata;
                        else hi_q <= avm_readdata;
                        state             <= widx == 2'd0 ? RD1 : RD2;
                        avm_read          <= 1'b1;
                        avm_begintransfer <= 1'b1;
                        avm_address       <= {snap_idx, widx + 2'd1};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perf_counter_driver.sv
// tb_perf_counter_driver: scoreboard bench; stimulus pushes expected bus/snapshot
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_perf_counter_driver;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [7:0]  sec_go = 8'd0, sec_stop = 8'd0;
    logic        global_reset_req = 1'b0, snap_req = 1'b0;
    logic [2:0]  snap_sel = 3'd0;
    logic [63:0] snap_time;
    logic [31:0] snap_events;
    logic        snap_valid, busy;
    logic [15:0] dropped_count;
    logic [4:0]  avm_address;
    logic        avm_write, avm_read, avm_begintransfer;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_waitrequest = 1'b0;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [63:0] t;
    } exp_t;
    exp_t        q[$];
    logic [31:0] mem [32];
    logic        rd_acc = 1'b0;
    logic [4:0]  rd_addr = 5'd0;
    int          total = 0, passed = 0;

    perf_counter_driver dut (
        .clk(clk), .reset_n(reset_n), .sec_go(sec_go), .sec_stop(sec_stop),
        .global_reset_req(global_reset_req), .snap_req(snap_req), .snap_sel(snap_sel),
        .snap_time(snap_time), .snap_events(snap_events), .snap_valid(snap_valid),
        .dropped_count(dropped_count), .busy(busy), .avm_address(avm_address),
        .avm_write(avm_write), .avm_read(avm_read), .avm_begintransfer(avm_begintransfer),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic push(input int kind, input logic [4:0] addr, input logic [31:0] data, input logic [63:0] t);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.t    = t;
        q.push_back(e);
    endtask

    task automatic observe(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: got kind %0d addr %0d, expected none", kind, avm_address);
            return;
        end
        e = q.pop_front();
        chk("sb_kind", 64'(kind), 64'(e.kind));
        if (kind == 2) begin
            chk("snap_time", snap_time, e.t);
            chk("snap_events", 64'(snap_events), 64'(e.data));
        end else begin
            chk("bus_addr", 64'(avm_address), 64'(e.addr));
            if (kind == 0) chk("bus_wdata", 64'(avm_writedata), 64'(e.data));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        rd_acc  = reset_n && avm_read && !avm_waitrequest;
        rd_addr = avm_address;
        if (reset_n && avm_write && !avm_waitrequest) observe(0);
        if (rd_acc) observe(1);
        if (reset_n && snap_valid) observe(2);
    end

    initial forever begin
        @(posedge clk);
        #1;
        avm_readdata = rd_acc ? mem[rd_addr] : 32'hDEAD_BEEF;
    end

    initial begin
        int lat;
        logic [5:0] pat;
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
        mem[20] = 32'h11;
        mem[21] = 32'h22;
        mem[22] = 32'h33;
        repeat (3) tick;
        reset_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_snap_time", snap_time, 0);
        chk("rst_dropped", dropped_count, 0);

        // single go write on section 3
        push(0, 5'd13, 32'd0, 64'd0);
        sec_go = 8'h08;
        tick;
        sec_go = 8'h00;
        chk("go3_busy_pending", busy, 1);
        chk("go3_no_strobe_yet", avm_write, 0);
        tick;
        chk("go3_strobe", avm_write, 1);
        chk("go3_begin", avm_begintransfer, 1);
        chk("go3_addr", avm_address, 13);
        tick;
        chk("go3_strobe_drop", avm_write, 0);
        chk("go3_busy_clear", busy, 0);

        // simultaneous requests: reset, stop 2, go 1
        push(0, 5'd0, 32'd1, 64'd0);
        push(0, 5'd8, 32'd0, 64'd0);
        push(0, 5'd5, 32'd0, 64'd0);
        sec_stop = 8'h04;
        sec_go = 8'h02;
        global_reset_req = 1'b1;
        tick;
        sec_stop = 8'h00;
        sec_go = 8'h00;
        global_reset_req = 1'b0;
        pat = 6'd0;
        for (int n = 0; n < 6; n++) begin
            tick;
            pat = {pat[4:0], avm_write};
        end
        chk("multi_write_spacing", pat, 6'b101010);
        chk("multi_busy_clear", busy, 0);

        // snapshot of section 5
        push(1, 5'd20, 32'd0, 64'd0);
        push(1, 5'd21, 32'd0, 64'd0);
        push(1, 5'd22, 32'd0, 64'd0);
        push(2, 5'd0, 32'h33, 64'h0000_0022_0000_0011);
        snap_sel = 3'd5;
        snap_req = 1'b1;
        tick;
        snap_req = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (snap_valid) begin
                lat = n;
                break;
            end
        end
        chk("snap_latency", 64'(lat), 7);
        tick;
        chk("snap_valid_pulse", snap_valid, 0);
        chk("snap_busy_clear", busy, 0);

        // stalled go write on section 6
        avm_waitrequest = 1'b1;
        push(0, 5'd25, 32'd0, 64'd0);
        sec_go = 8'h40;
        tick;
        sec_go = 8'h00;
        tick;
        chk("stall_first_strobe", avm_write, 1);
        chk("stall_first_begin", avm_begintransfer, 1);
        chk("stall_first_addr", avm_address, 25);
        for (int n = 0; n < 3; n++) begin
            tick;
            chk("stall_strobe_held", avm_write, 1);
            chk("stall_begin_low", avm_begintransfer, 0);
            chk("stall_addr_held", avm_address, 25);
        end
        tick;
        avm_waitrequest = 1'b0;
        chk("stall_fifth_strobe", avm_write, 1);
        chk("stall_fifth_begin", avm_begintransfer, 0);
        tick;
        chk("stall_strobe_drop", avm_write, 0);

        // coalesced go 0
        push(0, 5'd1, 32'd0, 64'd0);
        sec_go = 8'h01;
        tick;
        tick;
        sec_go = 8'h00;
        tick;
        tick;
        chk("coalesce_dropped", dropped_count, 1);
        chk("coalesce_busy", busy, 0);

        // asynchronous reset while in RD1
        push(1, 5'd20, 32'd0, 64'd0);
        snap_sel = 3'd5;
        snap_req = 1'b1;
        tick;
        snap_req = 1'b0;
        repeat (3) tick;
        chk("rd1_read", avm_read, 1);
        chk("rd1_addr", avm_address, 21);
        reset_n = 1'b0;
        #1;
        chk("areset_read", avm_read, 0);
        chk("areset_begin", avm_begintransfer, 0);
        chk("areset_write", avm_write, 0);
        repeat (2) tick;
        reset_n = 1'b1;
        repeat (3) tick;
        chk("areset_snap_time", snap_time, 0);
        chk("areset_snap_events", snap_events, 0);
        chk("areset_busy", busy, 0);
        chk("areset_dropped", dropped_count, 0);

        // saturation: stalled stop 0 write while every request fires each cycle
        avm_waitrequest = 1'b1;
        sec_stop = 8'hFF;
        sec_go = 8'hFF;
        repeat (10) tick;
        chk("sat_partial", dropped_count, 144);
        repeat (5000) tick;
        chk("sat_full", dropped_count, 16'hFFFF);
        sec_stop = 8'h00;
        sec_go = 8'h00;
        for (int s = 0; s < 8; s++) push(0, 5'(4 * s), 32'd0, 64'd0);
        for (int s = 0; s < 8; s++) push(0, 5'(4 * s + 1), 32'd0, 64'd0);
        avm_waitrequest = 1'b0;
        for (int n = 0; n < 200 && busy; n++) tick;
        chk("drain_busy", busy, 0);
        chk("sat_hold", dropped_count, 16'hFFFF);
        tick;
        chk("sb_empty", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
